// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle CPU control unit: fetch over the bus, latch IR, then sequence the datapath
// selects/strobes through decode, execute, memory and writeback with bus timeout tracking.
//   state      | meaning
//   IDLE       | parked, waiting for RUN
//   FETCH_REQ  | bus read request at PC
//   FETCH_WAIT | waiting for instruction word
//   DECODE     | PC+4, dispatch on opcode
//   EXEC       | JMP: load PC from ALU
//   MEM_REQ    | LW/SW bus request at ALU address
//   MEM_WAIT   | waiting for LW data / SW completion
//   WB         | regfile write
//   HALTED     | HALT retired, waiting for RUN low
//   ERROR      | illegal opcode or bus timeout, sticky
module cpu_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             RUN,
    input  logic [31:0]      rdata,
    input  logic             rdata_valid,
    input  logic             write_done,
    output logic             start_transaction,
    output logic             mode_BUS,
    output logic [1:0]       addr_CS,
    output logic [2:0]       data_CS,
    output logic [1:0]       PC_CS,
    output logic             PC_mode,
    output logic             PC_EN,
    output logic [1:0]       ALU_CS,
    output logic             ALU_mode,
    output logic [2:0]       reg_CS,
    output logic             reg_wen,
    output logic [4:0]       reg_raddr1,
    output logic [4:0]       reg_raddr2,
    output logic [4:0]       reg_waddr,
    output logic [31:0]      IM,
    output logic             halted,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instr_count
);
    localparam int unsigned TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_ADDI = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_LI   = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [3:0] {
        IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC,
        MEM_REQ, MEM_WAIT, WB, HALTED, ERROR
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic [3:0]       op;
    logic             to_expired;
    logic             mem_resp;
    logic             boundary;
    logic             retire;

    assign op         = ir_q[31:28];
    assign to_expired = (TIMEOUT != 0) && (to_q == TO_LAST);
    assign mem_resp   = (op == OP_SW) ? write_done : rdata_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ir_q    <= '0;
            to_q    <= '0;
            err_q   <= '0;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            to_q    <= to_d;
            err_q   <= err_d;
            icnt_q  <= icnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        to_d     = to_q;
        err_d    = err_q;
        icnt_d   = icnt_q;
        boundary = 1'b0;
        retire   = 1'b0;
        unique case (state_q)
            IDLE:       if (RUN) state_d = FETCH_REQ;
            FETCH_REQ: begin
                state_d = FETCH_WAIT;
                to_d    = '0;
            end
            FETCH_WAIT: begin
                if (rdata_valid) begin
                    ir_d    = rdata;
                    state_d = DECODE;
                end else if (to_expired) begin
                    state_d = ERROR;
                    err_d   = 2'd2;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            DECODE: begin
                case (op)
                    OP_NOP: begin
                        retire   = 1'b1;
                        boundary = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_ADDI, OP_LI: state_d = WB;
                    OP_LW, OP_SW:                   state_d = MEM_REQ;
                    OP_JMP:                         state_d = EXEC;
                    OP_HALT: begin
                        retire  = 1'b1;
                        state_d = HALTED;
                    end
                    default: begin
                        state_d = ERROR;
                        err_d   = 2'd1;
                    end
                endcase
            end
            EXEC, WB: begin
                retire   = 1'b1;
                boundary = 1'b1;
            end
            MEM_REQ: begin
                state_d = MEM_WAIT;
                to_d    = '0;
            end
            MEM_WAIT: begin
                // A response in the final timeout cycle still completes the access.
                if (mem_resp) begin
                    if (op == OP_SW) begin
                        retire   = 1'b1;
                        boundary = 1'b1;
                    end else begin
                        state_d = WB;
                    end
                end else if (to_expired) begin
                    state_d = ERROR;
                    err_d   = 2'd2;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            HALTED:     if (!RUN) state_d = IDLE;
            ERROR:      state_d = ERROR;
            default:    state_d = IDLE;
        endcase
        if (boundary) state_d = RUN ? FETCH_REQ : IDLE;
        if (retire)   icnt_d  = icnt_q + CNT_W'(1);
    end

    always_comb begin
        start_transaction = 1'b0;
        mode_BUS          = 1'b0;
        addr_CS           = 2'd0;
        data_CS           = 3'd0;
        PC_CS             = 2'd0;
        PC_mode           = 1'b0;
        PC_EN             = 1'b0;
        ALU_CS            = 2'd0;
        ALU_mode          = 1'b0;
        reg_CS            = 3'd0;
        reg_wen           = 1'b0;
        if (state_q inside {DECODE, EXEC, MEM_REQ, MEM_WAIT, WB}) begin
            if (op inside {OP_ADD, OP_SUB, OP_ADDI, OP_LW, OP_SW, OP_JMP}) ALU_CS = 2'd2;
            ALU_mode = (op == OP_SUB);
        end
        case (state_q)
            FETCH_REQ: begin
                start_transaction = 1'b1;
                addr_CS           = 2'd3;
            end
            FETCH_WAIT: addr_CS = 2'd3;
            DECODE:     PC_EN = 1'b1;
            EXEC: begin
                PC_EN   = 1'b1;
                PC_mode = 1'b1;
                PC_CS   = 2'd0;
            end
            MEM_REQ, MEM_WAIT: begin
                start_transaction = (state_q == MEM_REQ);
                addr_CS           = 2'd0;
                mode_BUS          = (op == OP_SW);
                data_CS           = 3'd2;
            end
            WB: begin
                reg_wen = 1'b1;
                if (op == OP_LI)      reg_CS = 3'd4;
                else if (op == OP_LW) reg_CS = 3'd5;
                else                  reg_CS = 3'd0;
            end
            default: ;
        endcase
    end

    assign reg_raddr1  = ir_q[22:18];
    assign reg_raddr2  = ir_q[17:13];
    assign reg_waddr   = ir_q[27:23];
    assign IM          = {{19{ir_q[12]}}, ir_q[12:0]};
    assign halted      = (state_q == HALTED);
    assign error       = (state_q == ERROR);
    assign err_code    = err_q;
    assign instr_count = icnt_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: plays bus controller with random latencies and compares every
// cycle's control outputs against a per-instruction timeline built from the opcode rules.
module tb_cpu_ctrl_fsm;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst_n, RUN, rdata_valid, write_done;
    logic [31:0]      rdata;
    logic             start_transaction, mode_BUS, PC_mode, PC_EN, ALU_mode, reg_wen, halted, error;
    logic [1:0]       addr_CS, PC_CS, ALU_CS, err_code;
    logic [2:0]       data_CS, reg_CS;
    logic [4:0]       reg_raddr1, reg_raddr2, reg_waddr;
    logic [31:0]      IM;
    logic [CNT_W-1:0] instr_count;

    cpu_ctrl_fsm #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .RUN(RUN), .rdata(rdata), .rdata_valid(rdata_valid),
        .write_done(write_done), .start_transaction(start_transaction), .mode_BUS(mode_BUS),
        .addr_CS(addr_CS), .data_CS(data_CS), .PC_CS(PC_CS), .PC_mode(PC_mode), .PC_EN(PC_EN),
        .ALU_CS(ALU_CS), .ALU_mode(ALU_mode), .reg_CS(reg_CS), .reg_wen(reg_wen),
        .reg_raddr1(reg_raddr1), .reg_raddr2(reg_raddr2), .reg_waddr(reg_waddr), .IM(IM),
        .halted(halted), .error(error), .err_code(err_code), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef enum {P_IDLE, P_FREQ, P_FWAIT, P_DEC, P_EXEC, P_MREQ, P_MWAIT, P_WB, P_HALT, P_ERR} phase_t;

    int          tests = 0;
    int          fails = 0;
    int          count_m = 0;
    logic [31:0] ir_m = '0;
    bit          term;
    logic [19:0] ctl;
    logic [46:0] fields;

    assign ctl    = {start_transaction, mode_BUS, addr_CS, data_CS, PC_CS, PC_mode, PC_EN,
                     ALU_CS, ALU_mode, reg_CS, reg_wen, halted, error};
    assign fields = {reg_waddr, reg_raddr1, reg_raddr2, IM};

    function automatic logic [19:0] exp_ctl(input phase_t ph, input logic [31:0] ir);
        logic       st, md, pcm, pce, am, we, hl, er;
        logic [1:0] ad, pcs, ac;
        logic [2:0] dc, rc;
        logic [3:0] op;
        bit         in_instr;
        op = ir[31:28];
        {st, md, pcm, pce, am, we, hl, er} = '0;
        ad = '0; pcs = '0; ac = '0; dc = '0; rc = '0;
        in_instr = ph inside {P_DEC, P_EXEC, P_MREQ, P_MWAIT, P_WB};
        if (in_instr && op >= 4'd1 && op <= 4'd6) ac = 2'd2;
        if (in_instr && op == 4'd2) am = 1'b1;
        case (ph)
            P_FREQ:  begin st = 1'b1; ad = 2'd3; end
            P_FWAIT: ad = 2'd3;
            P_DEC:   pce = 1'b1;
            P_EXEC:  begin pce = 1'b1; pcm = 1'b1; end
            P_MREQ:  begin st = 1'b1; md = (op == 4'd5); dc = 3'd2; end
            P_MWAIT: begin md = (op == 4'd5); dc = 3'd2; end
            P_WB:    begin we = 1'b1; rc = (op == 4'd7) ? 3'd4 : (op == 4'd4) ? 3'd5 : 3'd0; end
            P_HALT:  hl = 1'b1;
            P_ERR:   er = 1'b1;
            default: ;
        endcase
        return {st, md, ad, dc, pcs, pcm, pce, ac, am, rc, we, hl, er};
    endfunction

    function automatic logic [46:0] exp_fields(input logic [31:0] ir);
        return {ir[27:23], ir[22:18], ir[17:13], {19{ir[12]}}, ir[12:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag, input logic [1:0] code);
        logic [CNT_W-1:0] c;
        c = count_m[CNT_W-1:0];
        check(tag, 64'({err_code, instr_count}), 64'({code, c}));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; RUN = 1'b0; rdata_valid = 1'b0; write_done = 1'b0;
        step();
        rst_n = 1'b1;
        count_m = 0;
        ir_m = '0;
        check("reset_ctl", 64'(ctl), 64'(exp_ctl(P_IDLE, '0)));
        check("reset_fields", 64'(fields), 64'(0));
        check_cnt("reset_cnt", 2'd0);
    endtask

    task automatic expect_error(input logic [1:0] code);
        check("err_ctl", 64'(ctl), 64'(exp_ctl(P_ERR, ir_m)));
        check_cnt("err_code_cnt", code);
        RUN = 1'b1;
        repeat (2) begin
            step();
            check("err_sticky", 64'(ctl), 64'(exp_ctl(P_ERR, ir_m)));
        end
        term = 1'b1;
    endtask

    // Wait phase: response on wait cycle `lat`; the opposite-direction response is random noise.
    task automatic bus_wait(input phase_t ph, input logic [31:0] ir_now, input int lat,
                            input bit is_wr, input logic [31:0] data, output bit ok);
        ok = 1'b0;
        for (int w = 1; w <= TIMEOUT; w++) begin
            check(ph == P_FWAIT ? "fetch_wait" : "mem_wait", 64'(ctl), 64'(exp_ctl(ph, ir_now)));
            if (w == lat) begin
                if (is_wr) write_done = 1'b1;
                else begin rdata_valid = 1'b1; rdata = data; end
            end else if (is_wr) begin
                rdata_valid = 1'($urandom_range(0, 1));
                rdata = $urandom();
            end else begin
                write_done = 1'($urandom_range(0, 1));
            end
            step();
            rdata_valid = 1'b0;
            write_done  = 1'b0;
            if (w == lat) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Precondition: DUT sits in FETCH_REQ. Leaves it in FETCH_REQ unless term is set.
    task automatic do_instr(input logic [31:0] ir, input int flat, input int mlat, input bit run_next);
        logic [3:0] op;
        bit         ok;
        op = ir[31:28];
        term = 1'b0;
        check("fetch_req", 64'(ctl), 64'(exp_ctl(P_FREQ, ir_m)));
        step();
        bus_wait(P_FWAIT, ir_m, flat, 1'b0, ir, ok);
        if (!ok) begin expect_error(2'd2); return; end
        ir_m = ir;
        check("decode", 64'(ctl), 64'(exp_ctl(P_DEC, ir)));
        check("ir_fields", 64'(fields), 64'(exp_fields(ir)));
        RUN = run_next;
        step();
        case (op)
            4'h0: count_m++;
            4'hF: begin
                count_m++;
                check("halted", 64'(ctl), 64'(exp_ctl(P_HALT, ir)));
                check_cnt("halt_cnt", 2'd0);
                step();
                check("halt_hold", 64'(ctl), 64'(exp_ctl(P_HALT, ir)));
                RUN = 1'b0;
                step();
                check("halt_to_idle", 64'(ctl), 64'(exp_ctl(P_IDLE, ir)));
                term = 1'b1;
                return;
            end
            4'h1, 4'h2, 4'h3, 4'h7: begin
                check("wb", 64'(ctl), 64'(exp_ctl(P_WB, ir)));
                step();
                count_m++;
            end
            4'h6: begin
                check("exec", 64'(ctl), 64'(exp_ctl(P_EXEC, ir)));
                step();
                count_m++;
            end
            4'h4, 4'h5: begin
                check("mem_req", 64'(ctl), 64'(exp_ctl(P_MREQ, ir)));
                step();
                bus_wait(P_MWAIT, ir, mlat, op == 4'h5, $urandom(), ok);
                if (!ok) begin expect_error(2'd2); return; end
                if (op == 4'h4) begin
                    check("lw_wb", 64'(ctl), 64'(exp_ctl(P_WB, ir)));
                    step();
                end
                count_m++;
            end
            default: begin expect_error(2'd1); return; end
        endcase
        check_cnt("retire_cnt", 2'd0);
        if (!run_next) begin
            check("run_low_idle", 64'(ctl), 64'(exp_ctl(P_IDLE, ir)));
            RUN = 1'b1;
            step();
        end
    endtask

    task automatic start_run();
        RUN = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  op;
        rst_n = 1'b0; RUN = 1'b0; rdata = '0; rdata_valid = 1'b0; write_done = 1'b0;
        repeat (2) step();
        do_reset();
        step();
        check("idle_no_run", 64'(ctl), 64'(exp_ctl(P_IDLE, '0)));
        start_run();

        do_instr({4'h3, 5'd1, 5'd0, 5'd0, 13'd5}, 1, 0, 1'b1);
        check_cnt("addi_cnt1", 2'd0);
        do_instr({4'h5, 5'd0, 5'd2, 5'd7, 13'd4}, 1, 3, 1'b1);
        do_instr({4'h4, 5'd3, 5'd2, 5'd0, 13'h1ffc}, 2, 3, 1'b1);
        do_instr({4'h6, 5'd0, 5'd4, 5'd0, 13'h40}, 1, 0, 1'b1);
        do_instr({4'h2, 5'd9, 5'd4, 5'd5, 13'd0}, 3, 0, 1'b0);
        do_instr({4'h7, 5'd31, 5'd0, 5'd0, 13'h1234}, 1, 0, 1'b1);
        do_instr({4'h0, 28'd0}, TIMEOUT, 0, 1'b1);
        do_instr({4'h4, 5'd6, 5'd1, 5'd0, 13'd8}, 1, TIMEOUT, 1'b1);

        for (int i = 0; i < 60; i++) begin
            r  = $urandom();
            op = 4'($urandom_range(0, 7));
            do_instr({op, r[27:0]}, $urandom_range(1, TIMEOUT), $urandom_range(1, TIMEOUT),
                     $urandom_range(0, 4) != 0);
        end

        do_instr({4'h0, 28'd0}, TIMEOUT + 1, 0, 1'b1);
        check("fetch_timeout_term", 64'(term), 64'(1));
        do_reset();
        start_run();
        do_instr({4'h0, 28'd0}, 1, 0, 1'b1);
        do_instr({4'h4, 5'd2, 5'd1, 5'd0, 13'd0}, 1, TIMEOUT + 1, 1'b1);
        check("mem_timeout_term", 64'(term), 64'(1));

        do_reset();
        start_run();
        do_instr({4'h1, 5'd1, 5'd2, 5'd3, 13'd0}, 1, 0, 1'b1);
        do_instr({4'hA, 28'h0abcdef}, 1, 0, 1'b1);
        check("illegal_term", 64'(term), 64'(1));

        do_reset();
        start_run();
        do_instr({4'h3, 5'd2, 5'd0, 5'd0, 13'd1}, 2, 0, 1'b1);
        do_instr({4'hF, 28'd0}, 1, 0, 1'b1);
        check_cnt("after_halt_cnt", 2'd0);

        start_run();
        do_instr({4'h0, 28'd0}, 1, 0, 1'b1);
        check("mid_fetch_req", 64'(ctl), 64'(exp_ctl(P_FREQ, ir_m)));
        step();
        rdata_valid = 1'b1; rdata = {4'h5, 5'd0, 5'd1, 5'd2, 13'd4};
        step();
        rdata_valid = 1'b0;
        ir_m = rdata;
        step();
        step();
        check("mid_mem_wait", 64'(ctl), 64'(exp_ctl(P_MWAIT, ir_m)));
        do_reset();
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        check("late_wdone_idle", 64'(ctl), 64'(exp_ctl(P_IDLE, '0)));
        check_cnt("late_wdone_cnt", 2'd0);
        start_run();
        do_instr({4'h0, 28'd0}, 1, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control unit that sequences the CPU core datapath: PC counter, ALU, regfile write mux, regfile and bus controller.
- Fetches an instruction over the bus controller, latches it in an internal IR, then drives all datapath select and enable lines through decode, execute, memory and writeback.
- Tracks bus response timeouts and counts retired instructions.

Parameters:
- TIMEOUT, 64: max cycles waiting for rdata_valid/write_done before entering ERROR; 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous active-low reset
- RUN  in  1  start/continue execution
- rdata  in  32  read data from the bus controller
- rdata_valid  in  1  read response
- write_done  in  1  write response
- start_transaction  out  1  one-cycle bus request pulse
- mode_BUS  out  1  bus direction: 0 read, 1 write
- addr_CS  out  2  address select: 0 ALU, 1 reg0, 2 reg1, 3 PC
- data_CS  out  3  write-data select: 0 ALU, 1 reg0, 2 reg1, 3 IM
- PC_CS  out  2  PC load source: 0 ALU, 1 reg0, 2 reg1, 3 IM
- PC_mode  out  1  0 = PC+4, 1 = load the PC_CS source
- PC_EN  out  1  PC update strobe
- ALU_CS  out  2  ALU num1 select: 0 PC, 1 IM, 2 reg0
- ALU_mode  out  1  0 add, 1 sub
- reg_CS  out  3  regfile write select: 0 ALU, 4 IM, 5 bus rdata
- reg_wen  out  1  regfile write enable
- reg_raddr1  out  5  rs1 = IR[22:18]
- reg_raddr2  out  5  rs2 = IR[17:13]
- reg_waddr  out  5  rd = IR[27:23]
- IM  out  32  sign-extended IR[12:0]
- halted  out  1  high in HALTED
- error  out  1  high in ERROR
- err_code  out  2  1 = illegal opcode, 2 = bus timeout
- instr_count  out  CNT_W  retired-instruction count

Behaviour:
- Reset (rst_n low at a clk edge): state = IDLE; IR, instr_count, timeout counter and err_code = 0. All strobes (start_transaction, PC_EN, reg_wen) = 0, all selects = 0. Reset overrides any state, including mid-transaction.
- Outputs are Moore: decoded from state and IR only, with no combinational path from any input.
- Opcode field is IR[31:28]:
  - 0 NOP
  - 1 ADD rd = rs1 + rs2
  - 2 SUB rd = rs1 - rs2
  - 3 ADDI rd = rs1 + imm
  - 4 LW rd = mem[rs1 + imm]
  - 5 SW mem[rs1 + imm] = rs2
  - 6 JMP PC = rs1 + imm
  - 7 LI rd = imm
  - 15 HALT
  - Any other value is illegal.
- IDLE: goes to FETCH_REQ when RUN = 1.
- FETCH_REQ (1 cycle): start_transaction = 1, mode_BUS = 0, addr_CS = 3. Goes to FETCH_WAIT.
- FETCH_WAIT: holds addr_CS = 3 and mode_BUS = 0. On rdata_valid, latches IR <= rdata and goes to DECODE.
- DECODE (1 cycle): PC_EN = 1, PC_mode = 0 (PC+4). Next state:
  - NOP: FETCH_REQ
  - ADD/SUB/ADDI/LI: WB
  - LW/SW: MEM_REQ
  - JMP: EXEC
  - HALT: HALTED
  - illegal: ERROR with err_code = 1
- ALU setup for register-operand ops: ALU_CS = 2 for ADD/SUB/ADDI/LW/SW/JMP. ALU_mode = 1 for SUB only.
- EXEC (JMP only): PC_EN = 1, PC_mode = 1, PC_CS = 0. Goes to FETCH_REQ.
- MEM_REQ (1 cycle): start_transaction = 1, addr_CS = 0, mode_BUS = 0 for LW or 1 for SW, data_CS = 2. Goes to MEM_WAIT.
- MEM_WAIT: holds the MEM_REQ selects.
  - LW: on rdata_valid goes to WB.
  - SW: on write_done goes to FETCH_REQ.
  - The response signal for the other direction is ignored.
- WB (1 cycle): reg_wen = 1. reg_CS = 0 for ALU ops, 4 for LI, 5 for LW (bus rdata is held valid by the bus controller). Goes to FETCH_REQ.
- Timeout:
  - Counter clears on entry to each WAIT state and increments each cycle without a response.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no response, go to ERROR with err_code = 2.
  - A response arriving in that same cycle wins; no error is raised.
- instr_count increments by 1, wrapping, on exit from WB, EXEC, MEM_WAIT (SW), DECODE (NOP) and on entry to HALTED. It does not increment on an illegal opcode.
- RUN deasserted mid-instruction: the current instruction completes. The FSM goes to IDLE instead of FETCH_REQ at the next instruction boundary.
- HALTED: holds until RUN = 0, then goes to IDLE. PC is left pointing past the HALT.
- ERROR: sticky; only reset clears it. No strobes are asserted.
- Bus selects stay stable from the REQ state through the end of the matching WAIT state.

Test Plan:
- Fetch ADDI: RUN=1, PC=0, mem[0] = {4'h3, rd=1, rs1=0, 13'd5}, 1-cycle bus latency -> one start_transaction pulse, PC_EN in DECODE, reg_wen in WB with waddr=1, reg_CS=0, ALU_CS=2. IR-to-retire = 5 cycles; instr_count=1.
- LW/SW: SW mem[rs1+4]=rs2 then LW into r3, write_done and rdata_valid each delayed 3 cycles -> mode_BUS=1 then 0, addr_CS=0 held through WAIT, WB with reg_CS=5 and waddr=3, instr_count=2.
- JMP: rs1+imm = 0x40 -> EXEC asserts PC_EN, PC_mode=1, PC_CS=0. Next FETCH_REQ has addr_CS=3 with PC=0x40.
- Timeout: TIMEOUT=8, no rdata_valid -> ERROR exactly 8 cycles after FETCH_REQ, err_code=2, no further strobes. Response arriving on cycle 8 -> no error.
- Illegal opcode 4'hA -> ERROR, err_code=1, instr_count unchanged. Then HALT program: halted=1; RUN=0 -> IDLE.
- Reset mid-MEM_WAIT: rst_n=0 for one edge -> state IDLE, all strobes 0, instr_count=0. A late write_done after reset is ignored.
